led_frame_scheduler: RTL and testbench

//  Frame-level sequencer between the pattern sources and neopixel_controller.

---
 rtl/led_frame_scheduler_pkg.sv | 28 ++
 rtl/led_frame_scheduler_pixel_dimmer.sv | 21 ++
 rtl/led_frame_scheduler.sv | 163 ++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_scheduler_pkg.sv
// Shared definitions for the LED frame scheduler.
// Holds strip geometry, GRB field offsets, FSM state encodings and the per-channel
// brightness scaling helper used by the pixel dimmer.
package led_frame_scheduler_pkg;

  localparam int unsigned LedCount     = 48;
  localparam int unsigned PxCountWidth = 6;

  // Bit offsets of each 8-bit channel inside a 24-bit GRB word
  localparam int unsigned GrbGOffset = 16;
  localparam int unsigned GrbROffset = 8;
  localparam int unsigned GrbBOffset = 0;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StSend  = 3'd2,
    StLatch = 3'd3,
    StWait  = 3'd4
  } sched_state_e;

  // (chan * (scale + 1)) >> 8; scale 255 is identity and scale 0 always yields 0.
  // The product never exceeds 255 * 256, so 16 bits hold it exactly.
  function automatic logic [7:0] scale_channel(input logic [7:0] chan, input logic [7:0] scale);
    return 8'(({8'd0, chan} * ({8'd0, scale} + 16'd1)) >> 8);
  endfunction

endpackage

// File: rtl/led_frame_scheduler_pixel_dimmer.sv
// Combinational global-brightness scaler for one GRB pixel.
// Ports:
//   pixel_i  24b GRB pixel in
//   scale_i  8b brightness, 255 = full
//   pixel_o  24b scaled GRB pixel, zero latency
module led_frame_scheduler_pixel_dimmer
  import led_frame_scheduler_pkg::*;
(
  input  logic [23:0] pixel_i,
  input  logic [7:0]  scale_i,
  output logic [23:0] pixel_o
);

  always_comb begin
    pixel_o = '0;
    pixel_o[GrbGOffset +: 8] = scale_channel(pixel_i[GrbGOffset +: 8], scale_i);
    pixel_o[GrbROffset +: 8] = scale_channel(pixel_i[GrbROffset +: 8], scale_i);
    pixel_o[GrbBOffset +: 8] = scale_channel(pixel_i[GrbBOffset +: 8], scale_i);
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame-level sequencer in front of the neopixel controller.
// Starts a frame, waits for the strip to finish (or times out), holds the latch gap,
// then paces the next start to a fixed frame period. Source select and brightness
// are captured only at frame start.
// Ports:
//   clk_i, reset_i (sync, active-high)
//   enable_i        run frames; when low, finish the current frame then idle
//   src_sel_i       requested source (0 = src0, 1 = src1)
//   brightness_i    global scale, 255 = full
//   src0/1_pixel_i  GRB pixels from the two pattern sources
//   next_px_num_i   pixel index requested by the strip (consumed by the sources)
//   strip_done_i    one-cycle end-of-frame pulse from the strip
//   strip_start_o   one-cycle start pulse to the strip
//   pixel_out_o     scaled pixel of the frame's source, combinational
//   active_src_o    source captured for the current frame
//   frame_count_o   frames started, wrapping
//   busy_o          not idle
//   overrun_o       sticky: frame plus latch overran the period
//   fault_o         sticky: strip never reported done
module led_frame_scheduler
  import led_frame_scheduler_pkg::*;
#(
  parameter int unsigned FramePeriod = 833333,
  parameter int unsigned LatchCycles = 15000,
  parameter int unsigned SendTimeout = 200000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    src_sel_i,
  input  logic [7:0]              brightness_i,
  input  logic [23:0]             src0_pixel_i,
  input  logic [23:0]             src1_pixel_i,
  input  logic [PxCountWidth-1:0] next_px_num_i,
  input  logic                    strip_done_i,
  output logic                    strip_start_o,
  output logic [23:0]             pixel_out_o,
  output logic                    active_src_o,
  output logic [15:0]             frame_count_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    fault_o
);

  localparam int unsigned PeriodWidth = 20;
  localparam int unsigned LatchWidth  = (LatchCycles > 1) ? $clog2(LatchCycles) : 1;
  localparam int unsigned SendWidth   = (SendTimeout > 1) ? $clog2(SendTimeout) : 1;

  localparam logic [PeriodWidth-1:0] PeriodMax = PeriodWidth'(FramePeriod - 1);
  // period_cnt reads 0 on the cycle after START, so reaching FramePeriod-2 in WAIT
  // puts the next START exactly FramePeriod cycles after the previous one.
  localparam logic [PeriodWidth-1:0] PeriodDue = PeriodWidth'(FramePeriod - 2);
  localparam logic [LatchWidth-1:0]  LatchLast = LatchWidth'(LatchCycles - 1);
  localparam logic [SendWidth-1:0]   SendLast  = SendWidth'(SendTimeout - 1);

  sched_state_e           state_q, state_d;
  logic [PeriodWidth-1:0] period_cnt_q, period_cnt_d;
  logic [LatchWidth-1:0]  latch_cnt_q, latch_cnt_d;
  logic [SendWidth-1:0]   send_cnt_q, send_cnt_d;
  logic                   active_src_q, active_src_d;
  logic [7:0]             bright_q, bright_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   overrun_q, overrun_d;
  logic                   fault_q, fault_d;

  // The index only steers the sources; it has no role inside the scheduler.
  logic unused_px_num;
  assign unused_px_num = ^next_px_num_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      period_cnt_q  <= '0;
      latch_cnt_q   <= '0;
      send_cnt_q    <= '0;
      active_src_q  <= 1'b0;
      bright_q      <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      latch_cnt_q   <= latch_cnt_d;
      send_cnt_q    <= send_cnt_d;
      active_src_q  <= active_src_d;
      bright_q      <= bright_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      fault_q       <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    latch_cnt_d   = latch_cnt_q;
    send_cnt_d    = send_cnt_q;
    active_src_d  = active_src_q;
    bright_d      = bright_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    fault_d       = fault_q;

    // Frame-period timer runs through SEND/LATCH/WAIT and saturates.
    if (state_q != StIdle && state_q != StStart && period_cnt_q != PeriodMax) begin
      period_cnt_d = period_cnt_q + PeriodWidth'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i) state_d = StStart;
      end
      StStart: begin
        active_src_d  = src_sel_i;
        bright_d      = brightness_i;
        frame_count_d = frame_count_q + 16'd1;
        period_cnt_d  = '0;
        send_cnt_d    = '0;
        state_d       = StSend;
      end
      StSend: begin
        // A done arriving on the timeout cycle wins: no fault.
        if (strip_done_i) begin
          latch_cnt_d = '0;
          state_d     = StLatch;
        end else if (send_cnt_q == SendLast) begin
          fault_d     = 1'b1;
          latch_cnt_d = '0;
          state_d     = StLatch;
        end else begin
          send_cnt_d = send_cnt_q + SendWidth'(1);
        end
      end
      StLatch: begin
        if (latch_cnt_q == LatchLast) begin
          if (period_cnt_q == PeriodMax) overrun_d = 1'b1;
          state_d = StWait;
        end else begin
          latch_cnt_d = latch_cnt_q + LatchWidth'(1);
        end
      end
      StWait: begin
        if (period_cnt_q >= PeriodDue) state_d = enable_i ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  led_frame_scheduler_pixel_dimmer u_dimmer (
    .pixel_i (active_src_q ? src1_pixel_i : src0_pixel_i),
    .scale_i (bright_q),
    .pixel_o (pixel_out_o)
  );

  assign strip_start_o = (state_q == StStart);
  assign active_src_o  = active_src_q;
  assign frame_count_o = frame_count_q;
  assign busy_o        = (state_q != StIdle);
  assign overrun_o     = overrun_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
module tb_led_frame_scheduler;

  localparam int unsigned Fp = 100;
  localparam int unsigned Lc = 10;
  localparam int unsigned St = 50;

  logic        clk = 1'b0;
  logic        reset, reset_ovr, enable, src_sel, strip_done, strip_done_ovr;
  logic [7:0]  brightness;
  logic [23:0] src0_pixel, src1_pixel;
  logic [5:0]  next_px_num;

  logic        strip_start, active_src, busy, overrun, fault;
  logic [23:0] pixel_out;
  logic [15:0] frame_count;
  logic        strip_start_ovr, active_src_ovr, busy_ovr, overrun_ovr, fault_ovr;
  logic [23:0] pixel_out_ovr;
  logic [15:0] frame_count_ovr;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  led_frame_scheduler #(.FramePeriod(Fp), .LatchCycles(Lc), .SendTimeout(St)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .src_sel_i(src_sel),
    .brightness_i(brightness), .src0_pixel_i(src0_pixel), .src1_pixel_i(src1_pixel),
    .next_px_num_i(next_px_num), .strip_done_i(strip_done), .strip_start_o(strip_start),
    .pixel_out_o(pixel_out), .active_src_o(active_src), .frame_count_o(frame_count),
    .busy_o(busy), .overrun_o(overrun), .fault_o(fault)
  );

  // Long send timeout so a late done can push frame+latch past the period.
  led_frame_scheduler #(.FramePeriod(Fp), .LatchCycles(Lc), .SendTimeout(200)) dut_ovr (
    .clk_i(clk), .reset_i(reset_ovr), .enable_i(enable), .src_sel_i(src_sel),
    .brightness_i(brightness), .src0_pixel_i(src0_pixel), .src1_pixel_i(src1_pixel),
    .next_px_num_i(next_px_num), .strip_done_i(strip_done_ovr),
    .strip_start_o(strip_start_ovr), .pixel_out_o(pixel_out_ovr),
    .active_src_o(active_src_ovr), .frame_count_o(frame_count_ovr), .busy_o(busy_ovr),
    .overrun_o(overrun_ovr), .fault_o(fault_ovr)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Scoreboard of expected strip_start cycles for the main DUT.
  int unsigned exp_start_q[$];

  always @(negedge clk) begin
    if (strip_start === 1'b1) begin
      if (exp_start_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_start: got start at cycle %0d, want no start", cyc);
      end else begin
        int unsigned e;
        e = exp_start_q.pop_front();
        check("start_cycle", cyc, e);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input bit ovr, output int unsigned t);
    int unsigned n;
    n = 0;
    while (((ovr ? strip_start_ovr : strip_start) !== 1'b1) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      n_total++;
      $display("FAIL start_timeout: got no start in %0d cycles, want a start", n);
    end
    t = cyc;
  endtask

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  bright;
    logic [23:0] exp;
  } dim_vec_t;

  dim_vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1);
  end

  initial begin
    int unsigned k, t, t2, t3, dcyc;

    vecs[0] = '{24'hFF8002, 8'd127, 24'h7F4001};
    vecs[1] = '{24'hFF8002, 8'd0,   24'h000000};
    vecs[2] = '{24'h102030, 8'd255, 24'h102030};
    vecs[3] = '{24'hFFFFFF, 8'd128, 24'h808080};
    vecs[4] = '{24'h01FF80, 8'd1,   24'h000101};
    vecs[5] = '{24'h646464, 8'd63,  24'h191919};

    reset = 1'b1; reset_ovr = 1'b1; enable = 1'b0; src_sel = 1'b0;
    strip_done = 1'b0; strip_done_ovr = 1'b0; brightness = 8'd255;
    src0_pixel = 24'h102030; src1_pixel = 24'hA0B0C0; next_px_num = 6'd0;
    tick(3);

    check("rst_strip_start", {31'd0, strip_start}, 32'd0);
    check("rst_active_src", {31'd0, active_src}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_pixel_out", {8'd0, pixel_out}, 32'd0);

    // Normal pacing, source switch mid-SEND, stop mid-SEND.
    reset = 1'b0; enable = 1'b1; k = cyc;
    exp_start_q.push_back(k + 1);
    exp_start_q.push_back(k + 1 + Fp);
    exp_start_q.push_back(k + 1 + 2 * Fp);
    wait_start(1'b0, t);
    tick(1);
    check("f1_frame_count", {16'd0, frame_count}, 32'd1);
    check("f1_busy", {31'd0, busy}, 32'd1);
    check("f1_pixel", {8'd0, pixel_out}, 32'h102030);
    tick(19); strip_done = 1'b1; tick(1); strip_done = 1'b0;

    wait_start(1'b0, t2);
    tick(1);
    check("f2_frame_count", {16'd0, frame_count}, 32'd2);
    src_sel = 1'b1;
    tick(5);
    check("f2_pixel_hold", {8'd0, pixel_out}, 32'h102030);
    check("f2_active_src", {31'd0, active_src}, 32'd0);
    tick(14); strip_done = 1'b1; tick(1); strip_done = 1'b0;

    wait_start(1'b0, t3);
    tick(1);
    check("f3_pixel_src1", {8'd0, pixel_out}, 32'hA0B0C0);
    check("f3_active_src", {31'd0, active_src}, 32'd1);
    check("f3_frame_count", {16'd0, frame_count}, 32'd3);
    enable = 1'b0;
    tick(19); strip_done = 1'b1; tick(1); strip_done = 1'b0;
    check("stop_busy_latch", {31'd0, busy}, 32'd1);
    tick(78);
    check("stop_busy_wait", {31'd0, busy}, 32'd1);
    tick(1);
    check("stop_idle", {31'd0, busy}, 32'd0);
    tick(50);
    check("sb_drained_1", exp_start_q.size(), 32'd0);
    check("f3_overrun", {31'd0, overrun}, 32'd0);
    check("f3_fault", {31'd0, fault}, 32'd0);

    // Strip never answers: timeout, latch, wait, normal pacing.
    src_sel = 1'b0; enable = 1'b1; k = cyc;
    exp_start_q.push_back(k + 1);
    exp_start_q.push_back(k + 1 + Fp);
    wait_start(1'b0, t);
    tick(St);
    check("to_fault_before", {31'd0, fault}, 32'd0);
    tick(1);
    check("to_fault_set", {31'd0, fault}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd1);
    wait_start(1'b0, t2);
    tick(1); enable = 1'b0;
    tick(19); strip_done = 1'b1; tick(1); strip_done = 1'b0;
    check("to_fault_sticky", {31'd0, fault}, 32'd1);
    tick(80);
    check("to_idle", {31'd0, busy}, 32'd0);
    check("sb_drained_2", exp_start_q.size(), 32'd0);

    // Overrun on the long-timeout instance; main DUT parked in reset.
    reset = 1'b1; enable = 1'b1; reset_ovr = 1'b0; k = cyc;
    wait_start(1'b1, t);
    check("ovr_first_start", t, k + 1);
    tick(95); strip_done_ovr = 1'b1; dcyc = cyc; tick(1); strip_done_ovr = 1'b0;
    tick(9);
    check("ovr_before_latch_end", {31'd0, overrun_ovr}, 32'd0);
    tick(1);
    check("ovr_set", {31'd0, overrun_ovr}, 32'd1);
    wait_start(1'b1, t2);
    check("ovr_next_start", t2, dcyc + 1 + Lc + 1);
    check("ovr_no_fault", {31'd0, fault_ovr}, 32'd0);
    tick(20); strip_done_ovr = 1'b1; tick(1); strip_done_ovr = 1'b0;
    wait_start(1'b1, t3);
    check("ovr_period_after", t3 - t2, Fp);
    check("ovr_sticky", {31'd0, overrun_ovr}, 32'd1);
    reset_ovr = 1'b1; enable = 1'b0;
    tick(1);

    // Brightness table: captured at START, later changes ignored.
    for (int i = 0; i < 6; i++) begin
      reset = 1'b1; enable = 1'b0;
      tick(1);
      reset = 1'b0; src_sel = 1'b0; src0_pixel = vecs[i].pix; brightness = vecs[i].bright;
      enable = 1'b1; k = cyc;
      exp_start_q.push_back(k + 1);
      wait_start(1'b0, t);
      enable = 1'b0;
      tick(1);
      check($sformatf("dim_vec%0d", i), {8'd0, pixel_out}, {8'd0, vecs[i].exp});
      brightness = ~vecs[i].bright;
      tick(2);
      check($sformatf("dim_hold%0d", i), {8'd0, pixel_out}, {8'd0, vecs[i].exp});
    end

    // Reset in the middle of SEND.
    reset = 1'b1; tick(1);
    reset = 1'b0; src_sel = 1'b1; brightness = 8'd255; enable = 1'b1; k = cyc;
    exp_start_q.push_back(k + 1);
    wait_start(1'b0, t);
    enable = 1'b0;
    tick(5);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_active_src", {31'd0, active_src}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_start", {31'd0, strip_start}, 32'd0);
    check("mrst_frame_count", {16'd0, frame_count}, 32'd0);
    check("mrst_active_src", {31'd0, active_src}, 32'd0);
    check("mrst_pixel", {8'd0, pixel_out}, 32'd0);
    check("mrst_fault", {31'd0, fault}, 32'd0);
    tick(20);
    check("mrst_stays_idle", {31'd0, busy}, 32'd0);
    check("sb_drained_3", exp_start_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
